sparc_exu_addsub_pwrctl: RTL and testbench

Power/clock sequencer for the EXU add/sub unit. It watches the decode-stage add/sub demand and, after a programmable idle interval, retains state and gates the clock. It then drops the power switch; on new demand it powers up, restores and releases the clock. It drives the unit's clock-enable, sleep, save and restore controls, and stalls decode while the adder is unavailable.

---
 rtl/sparc_exu_addsub_pwrctl_pkg.sv | 49 ++++
 rtl/sparc_exu_addsub_pwrctl_if.sv | 55 +++++
 rtl/sparc_exu_pwrctl_satcnt.sv | 27 ++
 rtl/sparc_exu_addsub_pwrctl.sv | 130 +++++++++++++
 tb/tb_sparc_exu_addsub_pwrctl.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/sparc_exu_addsub_pwrctl_pkg.sv
// EXU add/sub power sequencer: state encoding and per-state output decode.
// Shared by the sequencer top and its interface.
package sparc_exu_pwr_pkg;

  localparam int IDLE_W_DEF   = 8;
  localparam int WAKE_MIN_DEF = 4;

  typedef enum logic [2:0] {
    ST_ON      = 3'd0,
    ST_SAVE    = 3'd1,
    ST_CGATE   = 3'd2,
    ST_SLEEP   = 3'd3,
    ST_WAKE    = 3'd4,
    ST_RESTORE = 3'd5
  } pwr_st_e;

  typedef struct packed {
    logic cen;
    logic nsleep;
    logic save;
    logic nrestore;
    logic iso_en;
    logic stall_d;
    logic on_l;
  } pwr_out_t;

  localparam pwr_out_t OUT_ON      = 7'b1101000;
  localparam pwr_out_t OUT_SAVE    = 7'b1111011;
  localparam pwr_out_t OUT_CGATE   = 7'b0101111;
  localparam pwr_out_t OUT_SLEEP   = 7'b0001111;
  localparam pwr_out_t OUT_WAKE    = 7'b0101111;
  localparam pwr_out_t OUT_RESTORE = 7'b0100111;

  function automatic pwr_out_t st_decode(input pwr_st_e s);
    pwr_out_t o;
    o = OUT_ON;
    unique case (s)
      ST_ON:      o = OUT_ON;
      ST_SAVE:    o = OUT_SAVE;
      ST_CGATE:   o = OUT_CGATE;
      ST_SLEEP:   o = OUT_SLEEP;
      ST_WAKE:    o = OUT_WAKE;
      ST_RESTORE: o = OUT_RESTORE;
      default:    o = OUT_ON;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/sparc_exu_addsub_pwrctl_if.sv
// Control bundle between decode/power switch and the add/sub sequencer.
// Stats ports exist only with SPARC_EXU_PWRCTL_STATS_EN defined.
interface sparc_exu_addsub_pwrctl_if #(
  parameter int IDLE_W = 8
);
  logic              pwr_en;
  logic [IDLE_W-1:0] idle_thresh;
  logic              addsub_req_d;
  logic              pwr_good;
  logic              cen;
  logic              nsleep;
  logic              save;
  logic              nrestore;
  logic              iso_en;
  logic              stall_d;
  logic              addsub_on_l;
`ifdef SPARC_EXU_PWRCTL_STATS_EN
  logic [31:0]       sleep_cyc;
  logic [15:0]       wake_cnt_tot;

  modport master (
    output pwr_en, idle_thresh,
    output addsub_req_d, pwr_good,
    input  cen, nsleep, save,
    input  nrestore, iso_en,
    input  stall_d, addsub_on_l,
    input  sleep_cyc, wake_cnt_tot
  );

  modport slave (
    input  pwr_en, idle_thresh,
    input  addsub_req_d, pwr_good,
    output cen, nsleep, save,
    output nrestore, iso_en,
    output stall_d, addsub_on_l,
    output sleep_cyc, wake_cnt_tot
  );
`else
  modport master (
    output pwr_en, idle_thresh,
    output addsub_req_d, pwr_good,
    input  cen, nsleep, save,
    input  nrestore, iso_en,
    input  stall_d, addsub_on_l
  );

  modport slave (
    input  pwr_en, idle_thresh,
    input  addsub_req_d, pwr_good,
    output cen, nsleep, save,
    output nrestore, iso_en,
    output stall_d, addsub_on_l
  );
`endif
endinterface

// File: rtl/sparc_exu_pwrctl_satcnt.sv
// Saturating up-counter with synchronous clear (clear wins).
// Used for the idle and wake interval counters.
module sparc_exu_pwrctl_satcnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !(&r_cnt)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/sparc_exu_addsub_pwrctl.sv
// Add/sub unit power sequencer: idle -> save -> clock gate -> rail off, and back.
// Optional stats counters: define SPARC_EXU_PWRCTL_STATS_EN.
module sparc_exu_addsub_pwrctl
  import sparc_exu_pwr_pkg::*;
#(
  parameter int IDLE_W   = IDLE_W_DEF,
  parameter int WAKE_MIN = WAKE_MIN_DEF,
  parameter int WAKE_W   = 3
) (
  input  logic rclk,
  input  logic arst_l,
  sparc_exu_addsub_pwrctl_if.slave bus
);

  if ((1 << WAKE_W) <= WAKE_MIN) begin : g_bad_wake_w
    $error("WAKE_W too narrow for WAKE_MIN");
  end

  pwr_st_e           r_state;
  pwr_st_e           w_nxt;
  pwr_out_t          r_out;
  logic [IDLE_W-1:0] w_idle_cnt;
  logic [WAKE_W-1:0] w_wake_cnt;
  logic [IDLE_W:0]   w_idle_inc;
  logic              w_in_on;
  logic              w_in_wake;
  logic              w_go_save;
  logic              w_abort;
  logic              w_wake_ok;

  assign w_in_on   = (r_state == ST_ON);
  assign w_in_wake = (r_state == ST_WAKE);

  sparc_exu_pwrctl_satcnt #(.W(IDLE_W)) u_idle (
    .clk   (rclk),
    .rst_n (arst_l),
    .i_clr (!w_in_on || bus.addsub_req_d),
    .i_inc (1'b1),
    .o_cnt (w_idle_cnt)
  );

  sparc_exu_pwrctl_satcnt #(.W(WAKE_W)) u_wake (
    .clk   (rclk),
    .rst_n (arst_l),
    .i_clr (!w_in_wake),
    .i_inc (1'b1),
    .o_cnt (w_wake_cnt)
  );

  // Count includes the current idle cycle, so compare idle_cnt+1.
  assign w_idle_inc = {1'b0, w_idle_cnt} + 1'b1;

  assign w_go_save = bus.pwr_en
                  && (|bus.idle_thresh)
                  && !bus.addsub_req_d
                  && (w_idle_inc >= {1'b0, bus.idle_thresh});

  assign w_abort = bus.addsub_req_d || !bus.pwr_en;

  assign w_wake_ok = bus.pwr_good
                  && (w_wake_cnt >= WAKE_W'(WAKE_MIN - 1));

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      ST_ON: begin
        if (w_go_save) w_nxt = ST_SAVE;
      end
      ST_SAVE: begin
        w_nxt = w_abort ? ST_ON : ST_CGATE;
      end
      ST_CGATE: begin
        w_nxt = w_abort ? ST_ON : ST_SLEEP;
      end
      ST_SLEEP: begin
        if (w_abort) w_nxt = ST_WAKE;
      end
      ST_WAKE: begin
        if (w_wake_ok) w_nxt = ST_RESTORE;
      end
      ST_RESTORE: begin
        w_nxt = ST_ON;
      end
      default: begin
        w_nxt = ST_ON;
      end
    endcase
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      r_state <= ST_ON;
      r_out   <= OUT_ON;
    end else begin
      r_state <= w_nxt;
      r_out   <= st_decode(w_nxt);
    end
  end

  assign bus.cen         = r_out.cen;
  assign bus.nsleep      = r_out.nsleep;
  assign bus.save        = r_out.save;
  assign bus.nrestore    = r_out.nrestore;
  assign bus.iso_en      = r_out.iso_en;
  assign bus.stall_d     = r_out.stall_d;
  assign bus.addsub_on_l = r_out.on_l;

`ifdef SPARC_EXU_PWRCTL_STATS_EN
  logic [15:0] r_wake_tot;

  sparc_exu_pwrctl_satcnt #(.W(32)) u_sleep_cyc (
    .clk   (rclk),
    .rst_n (arst_l),
    .i_clr (1'b0),
    .i_inc (!r_out.nsleep),
    .o_cnt (bus.sleep_cyc)
  );

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      r_wake_tot <= '0;
    end else if (r_state == ST_SLEEP && w_nxt == ST_WAKE) begin
      r_wake_tot <= r_wake_tot + 1'b1;
    end
  end

  assign bus.wake_cnt_tot = r_wake_tot;
`endif

endmodule

// File: tb/tb_sparc_exu_addsub_pwrctl.sv
// Directed bench: driver queues per-cycle expected outputs,
// a negedge monitor pops and compares them.
module tb_sparc_exu_addsub_pwrctl;

  // {cen,nsleep,save,nrestore,iso_en,stall_d,addsub_on_l}
  localparam logic [6:0] E_ON      = 7'b1101000;
  localparam logic [6:0] E_SAVE    = 7'b1111011;
  localparam logic [6:0] E_CGATE   = 7'b0101111;
  localparam logic [6:0] E_SLEEP   = 7'b0001111;
  localparam logic [6:0] E_WAKE    = 7'b0101111;
  localparam logic [6:0] E_RESTORE = 7'b0100111;

  typedef struct {
    logic [6:0] v;
    int         id;
    string      nm;
  } exp_t;

  exp_t       sb[$];
  exp_t       m_x;
  logic [6:0] m_got;
  logic       rclk   = 1'b0;
  logic       arst_l = 1'b0;
  logic       g_rst  = 1'b0;
  logic [7:0] g_thr  = 8'd0;
  string      g_ph   = "reset";
  int         n_vec  = 0;
  int         n_err  = 0;
  int         n_push = 0;

  sparc_exu_addsub_pwrctl_if #(.IDLE_W(8)) bus ();

  sparc_exu_addsub_pwrctl #(
    .IDLE_W   (8),
    .WAKE_MIN (4),
    .WAKE_W   (3)
  ) u_dut (
    .rclk   (rclk),
    .arst_l (arst_l),
    .bus    (bus)
  );

  always #5 rclk = ~rclk;

  task automatic step(input logic [6:0] e,
                      input logic req,
                      input logic en,
                      input logic pg);
    exp_t x;
    @(posedge rclk);
    #1;
    arst_l           = g_rst;
    bus.addsub_req_d = req;
    bus.pwr_en       = en;
    bus.pwr_good     = pg;
    bus.idle_thresh  = g_thr;
    x.v  = e;
    x.id = n_push;
    x.nm = g_ph;
    n_push++;
    sb.push_back(x);
  endtask

  always @(negedge rclk) begin
    if (sb.size() != 0) begin
      m_x   = sb.pop_front();
      m_got = {bus.cen, bus.nsleep, bus.save,
               bus.nrestore, bus.iso_en,
               bus.stall_d, bus.addsub_on_l};
      n_vec++;
      if (m_got !== m_x.v) begin
        n_err++;
        $display("FAIL vec%0d %s: got %b expected %b",
                 m_x.id, m_x.nm, m_got, m_x.v);
      end
    end
  end

  initial begin
    bus.addsub_req_d = 1'b0;
    bus.pwr_en       = 1'b0;
    bus.pwr_good     = 1'b0;
    bus.idle_thresh  = '0;

    g_ph = "reset";
    g_rst = 1'b0;
    step(E_ON, 0, 0, 0);
    step(E_ON, 0, 0, 0);
    g_rst = 1'b1;
    step(E_ON, 0, 0, 0);

    g_ph = "thresh0";
    g_thr = 8'd0;
    for (int i = 0; i < 12; i++) step(E_ON, 0, 1, 0);

    g_ph = "req_every3";
    g_thr = 8'd3;
    for (int i = 0; i < 4; i++) begin
      step(E_ON, 1, 1, 0);
      step(E_ON, 0, 1, 0);
      step(E_ON, 0, 1, 0);
    end

    g_ph = "powerdown";
    g_thr = 8'd5;
    step(E_ON, 1, 1, 0);
    for (int i = 0; i < 5; i++) step(E_ON, 0, 1, 0);
    step(E_SAVE, 0, 1, 0);
    step(E_CGATE, 0, 1, 0);
    step(E_SLEEP, 0, 1, 0);
    step(E_SLEEP, 0, 1, 0);

    g_ph = "wakeup";
    step(E_SLEEP, 1, 1, 1);
    for (int i = 0; i < 4; i++) step(E_WAKE, 1, 1, 1);
    step(E_RESTORE, 1, 1, 1);
    step(E_ON, 1, 1, 1);
    step(E_ON, 1, 1, 1);

    g_ph = "pg_hold";
    g_thr = 8'd2;
    step(E_ON, 0, 1, 0);
    step(E_ON, 0, 1, 0);
    step(E_SAVE, 0, 1, 0);
    step(E_CGATE, 0, 1, 0);
    step(E_SLEEP, 1, 1, 0);
    for (int i = 0; i < 20; i++) step(E_WAKE, 1, 1, 0);
    step(E_WAKE, 1, 1, 1);
    step(E_RESTORE, 1, 1, 1);
    step(E_ON, 1, 1, 0);

    g_ph = "save_abort";
    step(E_ON, 0, 1, 0);
    step(E_ON, 0, 1, 0);
    step(E_SAVE, 1, 1, 0);
    step(E_ON, 1, 1, 0);

    g_ph = "cgate_abort";
    step(E_ON, 0, 1, 0);
    step(E_ON, 0, 1, 0);
    step(E_SAVE, 0, 1, 0);
    step(E_CGATE, 0, 0, 0);
    step(E_ON, 0, 0, 0);
    step(E_ON, 0, 0, 0);

    g_ph = "reset_in_sleep";
    step(E_ON, 1, 1, 0);
    step(E_ON, 0, 1, 0);
    step(E_ON, 0, 1, 0);
    step(E_SAVE, 0, 1, 0);
    step(E_CGATE, 0, 1, 0);
    step(E_SLEEP, 0, 1, 0);
    step(E_SLEEP, 0, 1, 0);
    g_rst = 1'b0;
    step(E_ON, 0, 0, 0);
    g_rst = 1'b1;
    step(E_ON, 0, 0, 0);
    step(E_ON, 0, 0, 0);

    repeat (3) @(posedge rclk);
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
